gray_count_receiver: RTL
========================

// Module: gray_count_receiver
// PURPOSE
//  Receive end of a Gray-coded count bus: samples a free-running Gray count
//  (e.g. a Gray counter output crossing from another block/domain), decodes it
//  to binary, classifies every change as +1 / -1 / illegal, and tracks lock.
//  Sits downstream of a Gray counter; consumers use bin_out plus step/error pulses.
// PARAMETERS
//  DATA_WIDTH    4  width of gray_in / bin_out (>=2)
//  SYNC_STAGES   2  synchronizer flops ahead of the sample reg (>=1; used only with GRAY_RX_SYNC_EN)
//  LOCK_STEPS    4  consecutive legal steps required to assert locked (>=1)
//  ERR_CNT_WIDTH 8  width of saturating error counter
// PORTS
//  clk        in   1              rising-edge clock, sole clock
//  reset      in   1              asynchronous, active-high reset
//  gray_in    in   DATA_WIDTH     Gray-coded count, sampled every clk
//  bin_out    out  DATA_WIDTH     decoded binary of last accepted sample
//  up_pulse   out  1              1-cycle: accepted change was +1 (mod 2^DATA_WIDTH)
//  down_pulse out  1              1-cycle: accepted change was -1 (mod 2^DATA_WIDTH)
//  wrap_pulse out  1              1-cycle: step crossed max<->0 (with up/down_pulse)
//  err_pulse  out  1              1-cycle: change was neither +1 nor -1
//  locked     out  1              LOCK_STEPS legal steps seen since last error/reset
//  err_count  out  ERR_CNT_WIDTH  saturating count of err_pulse events
// BEHAVIOUR
//  Reset (async assert, sync release): all flops 0; bin_out=0, all pulses 0,
//   locked=0, err_count=0, state=ACQ, good_cnt=0, fill_cnt=0.
//  Sample path: gray_in -> [sync flops] -> g_q. Decode bin_n[i] = ^g_q[W-1:i]
//   (MSB copied; each lower bit = XOR of all higher Gray bits), combinational.
//  Compare bin_n against bin_prev (register). delta = bin_n - bin_prev, W-bit mod.
//  States:
//   ACQ    - pipeline filling; fill_cnt counts cycles until g_q holds a
//            post-reset sample (1 cycle, or SYNC_STAGES+1 with sync). Then
//            bin_prev<=bin_n, bin_out<=bin_n, no pulses, -> TRACK.
//   TRACK  - delta==0: hold, no pulse. delta==1: up_pulse; delta==all-ones:
//            down_pulse; either: bin_prev/bin_out<=bin_n, good_cnt++; when
//            good_cnt reaches LOCK_STEPS -> LOCKED, locked=1 same edge.
//            other delta: err_pulse, err_count++ (saturate at all-ones),
//            good_cnt<=0, bin_prev/bin_out<=bin_n (resync to new value).
//   LOCKED - legal steps/holds as TRACK (good_cnt frozen); illegal delta:
//            err_pulse, err_count++, locked<=0, good_cnt<=0, -> TRACK.
//  Holds (delta==0) never clear good_cnt or locked.
//  wrap_pulse: up with bin_prev=all-ones->0, or down with 0->all-ones.
//  Latency: gray_in change -> bin_out/pulses update 2 clk later (no sync);
//   SYNC_STAGES+2 with sync. All outputs registered; pulses exactly 1 cycle.
//  Simultaneous: at most one of up/down/err per cycle; err_count saturation
//   holds value but err_pulse still fires.
//  Reset mid-operation: immediate return to reset values; re-ACQ, no pulse on
//   first sample after release regardless of value.
// CONFIGURATION
//  GRAY_RX_SYNC_EN defined: SYNC_STAGES-deep flop chain ahead of g_q for
//   asynchronous gray_in; ACQ fill = SYNC_STAGES+1 cycles.
//  Undefined: gray_in registered once into g_q (same-clock source); ACQ fill = 1.
// TESTING
//  1 Reset, gray_in=4'b0000 held -> after ACQ bin_out=0, no pulses, locked=0.
//  2 gray_in walks 0000,0001,0011,0010,0110 one per clk -> 4 up_pulse,
//    locked=1 on 4th, bin_out=4 at latency 2 (no sync).
//  3 Down from bin 1 to 0 to 15 (gray 0001,0000,1000) -> down_pulse x2,
//    wrap_pulse on 0->15, bin_out=15.
//  4 While locked, gray 0110 -> 0101 (bin 4->6) -> err_pulse, err_count=1,
//    locked=0, bin_out=6; 4 further legal steps re-lock.
//  5 ERR_CNT_WIDTH=2, 5 illegal jumps -> err_count saturates at 3, err_pulse x5.
//  6 Assert reset mid-walk while locked -> outputs 0 immediately; repeat with
//    GRAY_RX_SYNC_EN, SYNC_STAGES=2: latency 4, ACQ 3 cycles.

Source files
------------

// File: rtl/gray_count_receiver_if.sv
// Gray count receiver bus.
//   gray_in    : Gray-coded count driven by the source side
//   bin_out    : decoded binary of the last accepted sample
//   up_pulse   : accepted change was +1
//   down_pulse : accepted change was -1
//   wrap_pulse : step crossed max<->0 (alongside up/down_pulse)
//   err_pulse  : change was neither +1 nor -1
//   locked     : enough consecutive legal steps since the last error/reset
//   err_count  : saturating count of err_pulse events
// master: source/consumer side. slave: the receiver.
interface gray_count_receiver_if #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]    gray_in;
  logic [DATA_WIDTH-1:0]    bin_out;
  logic                     up_pulse;
  logic                     down_pulse;
  logic                     wrap_pulse;
  logic                     err_pulse;
  logic                     locked;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport master (
    output gray_in,
    input  bin_out, up_pulse, down_pulse, wrap_pulse, err_pulse, locked, err_count
  );

  modport slave (
    input  gray_in,
    output bin_out, up_pulse, down_pulse, wrap_pulse, err_pulse, locked, err_count
  );
endinterface

// File: rtl/gray_count_receiver.sv
// Gray count receiver: samples a free-running Gray count, decodes it to
// binary, classifies each change as +1 / -1 / illegal and tracks lock.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : gray_count_receiver_if.slave (gray_in in; bin_out, up/down/
//            wrap/err pulses, locked, err_count out; all outputs registered)
// Optional macro GRAY_RX_SYNC_EN inserts a SYNC_STAGES-deep synchronizer
// ahead of the sample register for an asynchronous gray_in source.
module gray_count_receiver #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned LOCK_STEPS    = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  gray_count_receiver_if.slave  bus
);

  if (DATA_WIDTH < 2 || SYNC_STAGES < 1 || LOCK_STEPS < 1) begin : g_bad_params
    $error("gray_count_receiver: illegal parameter value");
  end

`ifdef GRAY_RX_SYNC_EN
  localparam int unsigned FILL = SYNC_STAGES + 1;
`else
  localparam int unsigned FILL = 1;
`endif
  localparam int unsigned FW = $clog2(FILL + 1);
  localparam int unsigned GW = $clog2(LOCK_STEPS + 1);

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_t;

  state_t                   state_q, state_d;
  logic [FW-1:0]            fill_cnt_q, fill_cnt_d;
  logic [GW-1:0]            good_cnt_q, good_cnt_d;
  logic [DATA_WIDTH-1:0]    g_q, g_d;
  logic [DATA_WIDTH-1:0]    bin_prev_q, bin_prev_d;
  logic [DATA_WIDTH-1:0]    bin_out_q, bin_out_d;
  logic                     up_q, up_d;
  logic                     down_q, down_d;
  logic                     wrap_q, wrap_d;
  logic                     err_q, err_d;
  logic                     locked_q, locked_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0]    bin_n;
  logic [DATA_WIDTH-1:0]    delta;
  logic [GW-1:0]            good_inc;
  logic                     is_hold, is_up, is_dn;

`ifdef GRAY_RX_SYNC_EN
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = bus.gray_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    g_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end
`else
  always_comb g_d = bus.gray_in;
`endif

  // Gray->binary: each binary bit is the XOR of all Gray bits at or above it,
  // computed as a running XOR from the MSB down.
  always_comb begin
    bin_n = '0;
    bin_n[DATA_WIDTH-1] = g_q[DATA_WIDTH-1];
    for (int unsigned i = 0; i < DATA_WIDTH - 1; i++) begin
      bin_n[DATA_WIDTH-2-i] = bin_n[DATA_WIDTH-1-i] ^ g_q[DATA_WIDTH-2-i];
    end
  end

  always_comb begin
    delta    = bin_n - bin_prev_q;
    is_hold  = (delta == '0);
    is_up    = (delta == DATA_WIDTH'(1));
    is_dn    = (delta == '1);
    good_inc = good_cnt_q + GW'(1);
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    good_cnt_d  = good_cnt_q;
    bin_prev_d  = bin_prev_q;
    bin_out_d   = bin_out_q;
    up_d        = 1'b0;
    down_d      = 1'b0;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;
    err_count_d = err_count_q;

    case (state_q)
      ACQ: begin
        // The first post-reset sample only seeds the reference value.
        if (fill_cnt_q == FW'(FILL)) begin
          bin_prev_d = bin_n;
          bin_out_d  = bin_n;
          state_d    = TRACK;
        end else begin
          fill_cnt_d = fill_cnt_q + FW'(1);
        end
      end
      TRACK, LOCKED: begin
        if (is_hold) begin
          // hold: nothing changes, lock progress kept
        end else if (is_up || is_dn) begin
          up_d       = is_up;
          down_d     = is_dn;
          wrap_d     = (is_up && bin_prev_q == '1) || (is_dn && bin_prev_q == '0);
          bin_prev_d = bin_n;
          bin_out_d  = bin_n;
          if (state_q == TRACK) begin
            good_cnt_d = good_inc;
            if (good_inc == GW'(LOCK_STEPS)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end
        end else begin
          // Illegal jump: resync the reference to the new value.
          err_d       = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
          end
          good_cnt_d  = '0;
          bin_prev_d  = bin_n;
          bin_out_d   = bin_n;
          locked_d    = 1'b0;
          state_d     = TRACK;
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACQ;
      fill_cnt_q  <= '0;
      good_cnt_q  <= '0;
      g_q         <= '0;
      bin_prev_q  <= '0;
      bin_out_q   <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      good_cnt_q  <= good_cnt_d;
      g_q         <= g_d;
      bin_prev_q  <= bin_prev_d;
      bin_out_q   <= bin_out_d;
      up_q        <= up_d;
      down_q      <= down_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.bin_out    = bin_out_q;
  assign bus.up_pulse   = up_q;
  assign bus.down_pulse = down_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.err_pulse  = err_q;
  assign bus.locked     = locked_q;
  assign bus.err_count  = err_count_q;

endmodule
